cond_unit: RTL
==============

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL declare parameter RESET_FLAGS, default 4'b0000, the value loaded into the flag register on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with the port list:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  instruction valid / not stalled; 0 freezes all state.
- Cond  input  4  instruction condition field.
- ALU_Flags  input  4  ALU flags {Neg,Z,C,V} for the current instruction.
- FlagW  input  2  flag-write request: bit1 updates {Neg,Z}; bit0 updates {C,V}.
- PCS  input  1  decoder: instruction writes PC (branch).
- RegW  input  1  decoder: instruction writes the register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  decoder: compare-only instruction (CMP); suppresses the register write.
- CondEx  output  1  condition passed, evaluated against registered flags.
- PCSrc  output  1  gated PCS.
- RegWrite  output  1  gated RegW.
- MemWrite  output  1  gated MemW.
- Flags  output  4  registered flags {Neg,Z,C,V}.
- BranchTaken_q  output  1  registered one-cycle pulse, asserted the cycle after a taken branch.

Function
REQ-003 The block SHALL hold a 4-bit flag register, ordered {Neg,Z,C,V}, that drives Flags directly.
REQ-004 CondEx SHALL be combinational from Cond and the registered Flags, never from ALU_Flags. Encoding:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: Neg
- 0101 PL: !Neg
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: Neg==V
- 1011 LT: Neg!=V
- 1100 GT: !Z&(Neg==V)
- 1101 LE: Z|(Neg!=V)
- 1110 AL: 1
- 1111: 0 (reserved)
REQ-005 The write-enable outputs SHALL be gated as follows:
- PCSrc = PCS & CondEx & en.
- RegWrite = RegW & CondEx & en & !NoWrite.
- MemWrite = MemW & CondEx & en.
REQ-006 On a rising edge with en=1, CondEx=1 and FlagW[1]=1, Flags[3:2] SHALL load ALU_Flags[3:2].
REQ-007 On a rising edge with en=1, CondEx=1 and FlagW[0]=1, Flags[1:0] SHALL load ALU_Flags[1:0].
REQ-008 In any other cycle (en=0, CondEx=0, or FlagW bit clear), the affected flag bits SHALL hold their value.
REQ-009 Flag-update latency SHALL be one cycle; an instruction SHALL see flags written by the previous enabled instruction, with no same-cycle bypass.
REQ-010 BranchTaken_q SHALL register PCSrc every cycle, including en=0 cycles, where PCSrc=0 makes it deassert.
REQ-011 A conditional flag-setting instruction whose condition fails SHALL NOT modify Flags.
REQ-012 With en=0, all gated outputs SHALL be 0 and Flags SHALL hold; CondEx SHALL still reflect Cond against Flags.
REQ-013 Cond=1111 SHALL suppress all writes and flag updates.

Reset
REQ-014 While rst=1 at a rising edge, Flags SHALL load RESET_FLAGS and BranchTaken_q SHALL load 0, regardless of en and FlagW.
REQ-015 Reset SHALL take priority over a simultaneous flag update.
REQ-016 After reset with the default RESET_FLAGS, EQ SHALL evaluate 0 and NE SHALL evaluate 1.
REQ-017 The combinational outputs SHALL follow REQ-004 and REQ-005 during reset.

Verification
REQ-018 Scenario 1 (basic flag load and equality check):
- Reset, then en=1, Cond=1110, FlagW=11, ALU_Flags=0100.
- Required: Flags=0100 next cycle.
- Then Cond=0000, PCS=1: CondEx=1 and PCSrc=1; BranchTaken_q=1 the following cycle.
REQ-019 Scenario 2 (failed condition):
- With Flags=0100, apply Cond=0001, RegW=1, MemW=1, FlagW=11, ALU_Flags=1011.
- Required: RegWrite=0 and MemWrite=0; Flags remain 0100.
REQ-020 Scenario 3 (partial flag write):
- With Flags=0000, apply Cond=1110, FlagW=10, ALU_Flags=1111.
- Required: Flags=1100.
- Then FlagW=01, ALU_Flags=0011: Flags=1111.
REQ-021 Scenario 4 (signed compares):
- Flags=1000 gives LT=1, GE=0, GT=0, LE=1.
- Flags=1001 gives GE=1, GT=1.
- Flags=0010 gives HI=1; Flags=0110 gives LS=1.
REQ-022 Scenario 5 (stall, then reset over an update):
- en=0 with Cond=1110, FlagW=11, ALU_Flags=1111, PCS=1.
- Required: Flags unchanged; PCSrc=0; BranchTaken_q=0 next cycle.
- Then rst=1 with en=1, FlagW=11: Flags=RESET_FLAGS.
REQ-023 Scenario 6 (NoWrite): Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALU_Flags=0110 -> required: RegWrite=0 and Flags=0110 next cycle.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: flag register, condition check,
// and write-enable gating for the execute stage.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] Cond,
  input  logic [3:0] ALU_Flags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       BranchTaken_q
);

  logic [3:0] r_flags;
  logic       r_br;
  logic       w_condex;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_ge;
  logic       w_upd;

  assign w_n  = r_flags[3];
  assign w_z  = r_flags[2];
  assign w_c  = r_flags[1];
  assign w_v  = r_flags[0];
  assign w_ge = (w_n == w_v);

  // Decode the condition field against the registered flags only.
  always_comb begin
    w_condex = 1'b0;
    case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = !w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = !w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = !w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = !w_v;
      4'b1000: w_condex = w_c && !w_z;
      4'b1001: w_condex = !w_c || w_z;
      4'b1010: w_condex = w_ge;
      4'b1011: w_condex = !w_ge;
      4'b1100: w_condex = !w_z && w_ge;
      4'b1101: w_condex = w_z || !w_ge;
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_upd    = en && w_condex;
  assign CondEx   = w_condex;
  assign PCSrc    = PCS && w_upd;
  assign RegWrite = RegW && w_upd && !NoWrite;
  assign MemWrite = MemW && w_upd;
  assign Flags    = r_flags;
  assign BranchTaken_q = r_br;

  // Flag register with split {N,Z}/{C,V} write enables; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= RESET_FLAGS;
    end else begin
      if (w_upd && FlagW[1])
        r_flags[3:2] <= ALU_Flags[3:2];
      if (w_upd && FlagW[0])
        r_flags[1:0] <= ALU_Flags[1:0];
    end
  end

  // One-cycle delayed copy of the taken-branch strobe.
  always_ff @(posedge clk) begin
    if (rst)
      r_br <= 1'b0;
    else
      r_br <= PCSrc;
  end

endmodule
